// File: rtl/intc.sv
// Edge-triggered interrupt controller: pending/enable/claim/EOI register file and a
// three-state request handshake toward the control unit. INTC_SYNC_EN adds a 2-flop irq synchroniser.
module intc #(
    parameter int NUM_SRC = 8,
    parameter int ID_W    = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq,
    input  logic               int_ack,
    output logic               hwint,
    input  logic [1:0]         reg_addr,
    input  logic               reg_rd,
    input  logic               reg_wr,
    input  logic [31:0]        reg_wdata,
    output logic [31:0]        reg_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, ACTIVE} state_t;

    localparam logic [1:0] ADDR_PENDING = 2'd0;
    localparam logic [1:0] ADDR_ENABLE  = 2'd1;
    localparam logic [1:0] ADDR_CLAIM   = 2'd2;
    localparam logic [1:0] ADDR_EOI     = 2'd3;

    state_t             state, state_next;
    logic [NUM_SRC-1:0] sampled, prev, rise;
    logic [NUM_SRC-1:0] pending, pending_next, enable, req, grant;
    logic [ID_W-1:0]    claim, winner;
    logic               any, ack_take, wr_pending, wr_enable, wr_eoi;
    logic               unused_wdata;

`ifdef INTC_SYNC_EN
    logic [NUM_SRC-1:0] sync_meta;

    // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_meta <= '0;
            sampled   <= '0;
        end else begin
            sync_meta <= irq;
            sampled   <= sync_meta;
        end
    end
`else
    // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) sampled <= '0;
        else     sampled <= irq;
    end
`endif

    assign rise         = sampled & ~prev;
    assign req          = pending & enable;
    assign any          = |req;
    assign grant        = req & (~req + NUM_SRC'(1));
    assign ack_take     = (state == REQ) && int_ack && any;
    assign wr_pending   = reg_wr && (reg_addr == ADDR_PENDING);
    assign wr_enable    = reg_wr && (reg_addr == ADDR_ENABLE);
    assign wr_eoi       = reg_wr && (reg_addr == ADDR_EOI);
    assign hwint        = (state == REQ);
    assign unused_wdata = ^reg_wdata[31:NUM_SRC];

    always_comb begin
        winner = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) winner = ID_W'(i);
        end
    end

    // A new edge is OR-ed in last so it survives both a W1C and the claim clear.
    always_comb begin
        pending_next = pending;
        if (wr_pending) pending_next = pending_next & ~reg_wdata[NUM_SRC-1:0];
        if (ack_take)   pending_next = pending_next & ~grant;
        pending_next = pending_next | rise;
    end

    always_comb begin
        // NOTE: defaults first so every path assigns state_next and no latch is inferred.
        state_next = state;
        case (state)
            IDLE:    if (any) state_next = REQ;
            REQ:     if (!any) state_next = IDLE;
                     else if (int_ack) state_next = ACTIVE;
            ACTIVE:  if (wr_eoi) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            prev    <= '0;
            pending <= '0;
            enable  <= '0;
            claim   <= '0;
        end else begin
            state   <= state_next;
            prev    <= sampled;
            pending <= pending_next;
            if (wr_enable) enable <= reg_wdata[NUM_SRC-1:0];
            if (ack_take)  claim  <= winner;
        end
    end

    always_comb begin
        reg_rdata = '0;
        if (reg_rd) begin
            case (reg_addr)
                ADDR_PENDING: reg_rdata = 32'(pending);
                ADDR_ENABLE:  reg_rdata = 32'(enable);
                ADDR_CLAIM: begin
                    reg_rdata     = 32'(claim);
                    reg_rdata[31] = (state == ACTIVE);
                end
                default:      reg_rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_intc.sv
// Directed bench for intc: latency, priority claim, enable gating, W1C races,
// stray ack/EOI and reset with a held line. Inputs change on negedge; outputs sampled there.
module tb_intc;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  irq;
    logic        int_ack;
    logic        hwint;
    logic [1:0]  reg_addr;
    logic        reg_rd;
    logic        reg_wr;
    logic [31:0] reg_wdata;
    logic [31:0] reg_rdata;

    int n_cmp = 0;
    int n_err = 0;

`ifdef INTC_SYNC_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    intc #(.NUM_SRC(8), .ID_W(5)) dut (
        .clk(clk), .rst(rst), .irq(irq), .int_ack(int_ack), .hwint(hwint),
        .reg_addr(reg_addr), .reg_rd(reg_rd), .reg_wr(reg_wr),
        .reg_wdata(reg_wdata), .reg_rdata(reg_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic reg_write(input logic [1:0] addr, input logic [31:0] data);
        reg_wr = 1'b1; reg_addr = addr; reg_wdata = data;
        @(negedge clk);
        reg_wr = 1'b0; reg_wdata = '0;
    endtask

    task automatic reg_read(input logic [1:0] addr, output logic [31:0] data);
        reg_rd = 1'b1; reg_addr = addr;
        #1 data = reg_rdata;
        reg_rd = 1'b0;
    endtask

    task automatic ack_pulse();
        int_ack = 1'b1;
        @(negedge clk);
        int_ack = 1'b0;
    endtask

    task automatic wait_hwint(input int budget, output int n);
        n = 0;
        while (hwint !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        logic [31:0] d;
        int          n;

        rst = 1'b1; irq = '0; int_ack = 1'b0;
        reg_addr = '0; reg_rd = 1'b0; reg_wr = 1'b0; reg_wdata = '0;
        cycles(2);
        rst = 1'b0;

        // Reset state
        check("rst_hwint", 32'(hwint), 32'd0);
        #1 check("rdata_idle", reg_rdata, 32'd0);
        reg_read(2'd0, d); check("rst_pending", d, 32'h0);
        reg_read(2'd1, d); check("rst_enable", d, 32'h0);
        reg_read(2'd2, d); check("rst_claim", d, 32'h0);

        // Single source latency
        reg_write(2'd1, 32'hFFFF_FF01);
        reg_read(2'd1, d); check("enable_mask", d, 32'h01);
        irq[0] = 1'b1;
        wait_hwint(10, n);
        check("lat_irq0", 32'(n), 32'(LAT));
        reg_read(2'd0, d); check("pend_irq0", d, 32'h1);
        irq[0] = 1'b0;
        ack_pulse();
        reg_read(2'd2, d); check("claim_irq0", d, 32'h8000_0000);
        reg_write(2'd3, 32'h0);
        reg_read(2'd2, d); check("claim_after_eoi0", d, 32'h0);

        // Priority: 5 and 2 together, 2 wins
        reg_write(2'd1, 32'hFF);
        irq = 8'h24;
        wait_hwint(10, n);
        check("hwint_52", 32'(hwint), 32'd1);
        ack_pulse();
        reg_read(2'd2, d); check("claim_2", d, 32'h8000_0002);
        reg_read(2'd0, d); check("pend_after_claim2", d, 32'h20);
        cycles(3);
        check("hwint_active", 32'(hwint), 32'd0);
        reg_write(2'd3, 32'h0);
        check("hwint_eoi_edge", 32'(hwint), 32'd0);
        reg_read(2'd2, d); check("claim_retained", d, 32'h2);
        cycles(1);
        check("hwint_src5", 32'(hwint), 32'd1);
        ack_pulse();
        reg_read(2'd2, d); check("claim_5", d, 32'h8000_0005);
        reg_write(2'd3, 32'h0);
        irq = '0;
        cycles(2);
        reg_read(2'd0, d); check("pend_empty", d, 32'h0);

        // Disabled source still latches
        reg_write(2'd1, 32'h00);
        irq[3] = 1'b1;
        cycles(6);
        reg_read(2'd0, d); check("pend_disabled", d, 32'h08);
        check("hwint_disabled", 32'(hwint), 32'd0);
        reg_write(2'd1, 32'h08);
        wait_hwint(2, n);
        check("hwint_enable3", 32'(hwint), 32'd1);

        // W1C in REQ drops the request
        reg_write(2'd0, 32'hFF);
        cycles(1);
        check("hwint_w1c", 32'(hwint), 32'd0);
        reg_read(2'd0, d); check("pend_w1c", d, 32'h0);

        // W1C coinciding with a rise keeps the bit
        irq[1] = 1'b1;
        cycles(LAT - 2);
        reg_write(2'd0, 32'h02);
        reg_read(2'd0, d); check("w1c_race", d, 32'h02);
        reg_write(2'd0, 32'hFF);
        irq = '0;
        cycles(2);

        // Stray int_ack in IDLE, stray EOI in REQ
        ack_pulse();
        reg_read(2'd2, d); check("claim_stray_ack", d, 32'h5);
        check("hwint_stray_ack", 32'(hwint), 32'd0);
        reg_write(2'd1, 32'hFF);
        irq[6] = 1'b1;
        wait_hwint(10, n);
        reg_write(2'd3, 32'h0);
        check("hwint_stray_eoi", 32'(hwint), 32'd1);
        reg_read(2'd2, d); check("claim_stray_eoi", d, 32'h5);
        ack_pulse();
        reg_read(2'd2, d); check("claim_6", d, 32'h8000_0006);

        // Reset while ACTIVE with irq[4] held high
        rst = 1'b1; irq = 8'h10;
        cycles(2);
        check("hwint_in_rst", 32'(hwint), 32'd0);
        rst = 1'b0;
        reg_read(2'd0, d); check("rst2_pending", d, 32'h0);
        reg_read(2'd1, d); check("rst2_enable", d, 32'h0);
        reg_read(2'd2, d); check("rst2_claim", d, 32'h0);
        cycles(6);
        reg_read(2'd0, d); check("held_edge", d, 32'h10);
        reg_write(2'd0, 32'h10);
        cycles(6);
        reg_read(2'd0, d); check("held_no_repeat", d, 32'h0);
        check("hwint_final", 32'(hwint), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
